// File: rtl/data_mem_responder.sv
// MEM-stage data RAM responder: fixed-latency word-addressed RAM with a
// MemReady handshake toward the hazard unit (low while an access is in flight).
module data_mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [31:0]         rdata_q;
    logic                req;
    logic                commit;
    logic [31:0]         mem [DEPTH];

    // Byte-lane bits and bits above the word index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{Addr[31:ADDR_W+2], Addr[1:0]};

    assign req = MemRead | MemWrite;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        MemReady = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                MemReady = ~req;
                if (req) begin
                    idx_d   = Addr[ADDR_W+1:2];
                    wdata_d = WriteData;
                    wr_d    = MemWrite;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                MemReady = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            if (commit && !wr_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Reset abandons an in-flight store, so the write is gated by reset too.
    always_ff @(posedge clk) begin
        if (!reset && commit && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ReadData = rdata_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected ReadData queued at request
// time from a reference memory, checked at the MemReady pulse.
module tb_data_mem_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned AW  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        Busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem[int];
    logic [31:0] last_rd;

    data_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .MemReady(MemReady), .Busy(Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && Busy && MemReady) done_cnt++;
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << AW));
    endfunction

    // Drives one request starting in the current (IDLE) cycle; inputs are
    // dropped and scrambled from cycle drop_after+1 onward.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int drop_after, input string name);
        int k;
        logic [31:0] exp;
        MemRead = rd; MemWrite = wr; Addr = addr; WriteData = data;
        if (wr) begin
            model_mem[widx(addr)] = data;
            exp_q.push_back(last_rd);
        end else begin
            last_rd = model_mem.exists(widx(addr)) ? model_mem[widx(addr)] : 32'h0;
            exp_q.push_back(last_rd);
        end
        @(negedge clk);
        vectors++;
        if (MemReady !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s cycle0: MemReady=%b Busy=%b, required 0/0", name, MemReady, Busy);
        end
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k > drop_after) begin
                MemRead = 1'b0; MemWrite = 1'b0;
                Addr = $urandom; WriteData = $urandom;
            end
            @(negedge clk);
        end while (MemReady !== 1'b1 && k < 20);
        vectors++;
        if (k != LAT + 1) begin
            miscompares++;
            $display("FAIL %s latency: MemReady high at cycle %0d, required %0d", name, k, LAT + 1);
        end
        exp = exp_q.pop_front();
        vectors++;
        if (ReadData !== exp) begin
            miscompares++;
            $display("FAIL %s data: ReadData=%h, required %h", name, ReadData, exp);
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (MemReady !== 1'b1 || Busy !== 1'b0 || ReadData !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: MemReady=%b Busy=%b ReadData=%h, required 1/0/0",
                         i, MemReady, Busy, ReadData);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 99, "store_10");
        idle_cycles(2);
        access(1'b1, 1'b0, 32'h10, 32'h0, 99, "load_10");
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        int start;
        start = done_cnt;
        access(1'b1, 1'b0, 32'h10, 32'h0, 99, "b2b_load1");
        access(1'b0, 1'b1, 32'h14, 32'hCAFEF00D, 99, "b2b_store");
        access(1'b1, 1'b0, 32'h14, 32'h0, 99, "b2b_load2");
        idle_cycles(4);
        vectors++;
        if (done_cnt - start != 3) begin
            miscompares++;
            $display("FAIL b2b_pulses: %0d MemReady pulses, required 3", done_cnt - start);
        end
    endtask

    task automatic test_both_set;
        access(1'b1, 1'b1, 32'h40, 32'h00000077, 99, "both_store");
        idle_cycles(1);
        access(1'b1, 1'b0, 32'h40, 32'h0, 99, "both_load");
        idle_cycles(1);
    endtask

    task automatic test_wrap;
        access(1'b0, 1'b1, 32'h1000, 32'h1, 99, "wrap_store");
        access(1'b1, 1'b0, 32'h0, 32'h0, 99, "wrap_load0");
        access(1'b1, 1'b0, 32'h3, 32'h0, 99, "wrap_load3");
        idle_cycles(1);
    endtask

    task automatic test_reset_busy;
        access(1'b0, 1'b1, 32'h20, 32'h00001234, 99, "rb_prestore");
        idle_cycles(1);
        MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; MemWrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = '0;
        @(negedge clk);
        vectors++;
        if (ReadData !== 32'h0 || Busy !== 1'b0 || MemReady !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_after_reset: ReadData=%h Busy=%b MemReady=%b, required 0/0/1",
                     ReadData, Busy, MemReady);
        end
        idle_cycles(2);
        access(1'b1, 1'b0, 32'h20, 32'h0, 99, "rb_load");
        idle_cycles(1);
    endtask

    task automatic test_drop;
        access(1'b0, 1'b1, 32'h30, 32'h55, 1, "drop_store");
        idle_cycles(2);
        access(1'b1, 1'b0, 32'h30, 32'h0, 1, "drop_load");
        idle_cycles(2);
        access(1'b1, 1'b0, 32'h30, 32'h0, 99, "drop_reload");
        idle_cycles(1);
        vectors++;
        if (ReadData !== 32'h55) begin
            miscompares++;
            $display("FAIL hold_rd: ReadData=%h, required 00000055", ReadData);
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_back_to_back;
        test_both_set;
        test_wrap;
        test_reset_busy;
        test_drop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
